demux_burst: RTL
================

// Module: demux_burst
// PURPOSE
//  Registered 1-to-2 stream demultiplexer for the SVD datapath. It is the
//  splitting counterpart of the registered 2:1 select stage.
//  Steers a single WIDTH-bit element stream into two output lanes, either by
//  explicit select or by automatic alternation every BURST elements
//  (e.g. column/row split in bidiagonalization). Each lane has a 1-deep output
//  register with valid/ready handshake; the msb of each lane is exported for
//  sign-driven control downstream.
// PARAMETERS
//  WIDTH   24  data width of in_data / outK_data
//  BURST   4   elements per lane before toggling in auto mode (>=1)
//  CNT_W   2   burst counter width, = max(1, clog2(BURST))
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  ce          in   1      clock enable for input acceptance and counter
//  mode        in   1      0 = manual (lane = sel), 1 = auto burst alternation
//  sel         in   1      manual lane select (0 -> lane 0, 1 -> lane 1)
//  in_data     in   WIDTH  input element
//  in_valid    in   1      input element valid
//  in_ready    out  1      input accepted this cycle when in_valid & in_ready
//  out0_data   out  WIDTH  lane 0 output register
//  out0_valid  out  1      lane 0 holds an undelivered element
//  out0_ready  in   1      lane 0 consumer ready
//  out1_data   out  WIDTH  lane 1 output register
//  out1_valid  out  1      lane 1 holds an undelivered element
//  out1_ready  in   1      lane 1 consumer ready
//  msb0, msb1  out  1      outK_data[WIDTH-1], combinational from register
//  lane        out  1      lane the next accepted element goes to
// BEHAVIOUR
//  - Reset (async, rst=1): outK_data=0, outK_valid=0, burst count=0,
//    auto lane=0. in_ready follows its equation (0 while ce=0).
//  - lane = sel when mode=0; lane = auto lane register when mode=1.
//  - Target lane K free = !outK_valid | outK_ready.
//    in_ready = ce & free(lane). Combinational, no dependence on in_valid.
//  - Accept (in_valid & in_ready) at edge N: outK_data<=in_data,
//    outK_valid<=1 after edge N. Latency is 1 cycle.
//    Throughput is 1/cycle per lane when the consumer keeps ready high.
//  - Drain: outK_valid & outK_ready & no new write to K -> outK_valid<=0.
//    outK_data holds its last value. Drain is independent of ce.
//  - Simultaneous drain and write to the same lane: the register is
//    overwritten and valid stays 1. No bubble.
//  - The non-target lane is untouched by an accept.
//  - Auto FSM, states LANE0 and LANE1, with count 0..BURST-1:
//    - On each accept in mode=1: if count==BURST-1, then count<=0 and
//      toggle state; else count<=count+1.
//    - BURST=1 toggles the lane on every accept.
//  - While mode=0, count<=0 and state<=LANE0 every cycle. Auto mode therefore
//    always starts at lane 0, count 0.
//  - ce=0: no accept, count and state hold. Output drain continues.
//  - Stalled target (outK_valid=1, outK_ready=0): in_ready=0; count and state
//    hold; the other lane keeps draining. No lookahead to the other lane.
//  - Reset mid-burst: all pending outputs are discarded (valid=0), the
//    counter clears, and the first post-reset accept goes to lane 0.
// TESTING
//  1 Reset: rst=1 pulse with no clock -> all outK_valid=0, outK_data=0,
//    lane=0, msb0=msb1=0.
//  2 Manual: mode=0, sel=1, in=0x800001 valid 1 cycle -> next cycle
//    out1_data=0x800001, out1_valid=1, msb1=1; out0 unchanged.
//  3 Auto BURST=4, both readys=1, stream 1..8 -> lane0 gets 1,2,3,4 and
//    lane1 gets 5,6,7,8, each 1 cycle after accept, in_ready=1 throughout.
//  4 Back-pressure: auto, out0_ready=0 after word 1 -> word 2 sees
//    in_ready=0, count held at 1. Raising out0_ready accepts word 2 with no
//    loss or duplication.
//  5 ce=0 for 3 cycles mid-burst (after word 2) -> in_ready=0, count held;
//    pending outputs still drain. Resume -> words 3,4 go to lane0, then
//    the lane toggles.
//  6 rst asserted after word 6 of 8 -> out1_valid=0 immediately. Post-reset
//    stream 9,10 -> lane0.

Source files
------------

// File: rtl/demux_burst_if.sv
// ----------------------------------------------------------------------------
// demux_burst_if
//   Stream bundle for the 1-to-2 burst demultiplexer. It carries the input
//   element stream and the two registered output lanes. Each of those has a
//   valid/ready handshake. It also carries the lane sign bits.
//
//   Signals
//     in_data/in_valid/in_ready      input element stream
//     out0_data/out0_valid/out0_ready  lane 0 output stream
//     out1_data/out1_valid/out1_ready  lane 1 output stream
//     msb0/msb1                        sign bit of each lane register
//
//   Modports
//     master : the environment side (produces input, consumes lanes)
//     slave  : the demultiplexer side
// ----------------------------------------------------------------------------
interface demux_burst_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             msb0;
    logic             msb1;

    modport master (
        output in_data, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
               msb0, msb1
    );

    modport slave (
        input  in_data, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid,
               msb0, msb1
    );
endinterface

// File: rtl/demux_burst.sv
// ----------------------------------------------------------------------------
// demux_burst
//   Registered 1-to-2 stream demultiplexer. A single WIDTH-bit element stream
//   is steered into one of two output lanes. The lane is chosen either by an
//   explicit select (manual mode) or by alternating every BURST accepted
//   elements (auto mode). Each lane has a 1-deep output register with a
//   valid/ready handshake.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     ce    clock enable for input acceptance and the burst counter
//     mode  0 = manual (lane = sel), 1 = auto burst alternation
//     sel   manual lane select
//     lane  lane that the next accepted element goes to
//     bus   stream bundle (input stream, two output lanes, lane msbs)
// ----------------------------------------------------------------------------
module demux_burst #(
    parameter int WIDTH = 24,
    parameter int BURST = 4,
    parameter int CNT_W = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             mode,
    input  logic             sel,
    output logic             lane,
    demux_burst_if.slave     bus
);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } laneState_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    laneState_t       state_q, state_d;
    logic [CNT_W-1:0] burstCnt_q, burstCnt_d;

    logic [WIDTH-1:0] out0Data_q, out0Data_d;
    logic [WIDTH-1:0] out1Data_q, out1Data_d;
    logic             out0Valid_q, out0Valid_d;
    logic             out1Valid_q, out1Valid_d;

    logic             laneSel;
    logic             lane0Free;
    logic             lane1Free;
    logic             accept;
    logic             write0;
    logic             write1;

    // Auto-mode state register. The burst counter and the lane state move
    // together, so they share one register process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LANE0;
            burstCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    // Next-state logic. Manual mode forces the FSM back to lane 0, count 0.
    // As a result, auto mode always starts a fresh burst. In auto mode only
    // an accepted element advances the count. This means ce=0 or a stalled
    // target lane holds both the count and the lane state.
    always_comb begin
        state_d    = state_q;
        burstCnt_d = burstCnt_q;
        if (!mode) begin
            state_d    = LANE0;
            burstCnt_d = '0;
        end else if (accept) begin
            if (burstCnt_q == LAST_CNT) begin
                burstCnt_d = '0;
                state_d    = (state_q == LANE0) ? LANE1 : LANE0;
            end else begin
                burstCnt_d = burstCnt_q + CNT_W'(1);
            end
        end
    end

    // Output logic of the FSM: the target lane, plus the input handshake
    // that depends on it. A lane counts as free when its register is empty
    // or when it is being drained this cycle. The other lane is never
    // considered, even if it is free.
    always_comb begin
        laneSel      = mode ? (state_q == LANE1) : sel;
        lane0Free    = !out0Valid_q || bus.out0_ready;
        lane1Free    = !out1Valid_q || bus.out1_ready;
        bus.in_ready = ce && (laneSel ? lane1Free : lane0Free);
        accept       = bus.in_valid && bus.in_ready;
        write0       = accept && !laneSel;
        write1       = accept && laneSel;
    end

    // Lane register next values. A write takes priority over a drain, so a
    // simultaneous drain and write keeps valid high with the new element.
    // Draining is independent of ce. Data holds after a drain.
    always_comb begin
        out0Data_d  = write0 ? bus.in_data : out0Data_q;
        out1Data_d  = write1 ? bus.in_data : out1Data_q;
        out0Valid_d = write0 || (out0Valid_q && !bus.out0_ready);
        out1Valid_d = write1 || (out1Valid_q && !bus.out1_ready);
    end

    // Lane output registers. Reset discards any pending element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0Data_q  <= '0;
            out1Data_q  <= '0;
            out0Valid_q <= 1'b0;
            out1Valid_q <= 1'b0;
        end else begin
            out0Data_q  <= out0Data_d;
            out1Data_q  <= out1Data_d;
            out0Valid_q <= out0Valid_d;
            out1Valid_q <= out1Valid_d;
        end
    end

    assign lane           = laneSel;
    assign bus.out0_data  = out0Data_q;
    assign bus.out1_data  = out1Data_q;
    assign bus.out0_valid = out0Valid_q;
    assign bus.out1_valid = out1Valid_q;
    assign bus.msb0       = out0Data_q[WIDTH-1];
    assign bus.msb1       = out1Data_q[WIDTH-1];

endmodule
